// File: rtl/dai_receiver_if.sv
// dai_receiver_if: serial DAI lines toward the receiver and the recovered
// left/right sample pair with its status strobes coming back.
interface dai_receiver_if #(parameter int bw_data = 16);
    logic               bck;
    logic               lrck;
    logic               sdata;
    logic [bw_data-1:0] ldata;
    logic [bw_data-1:0] rdata;
    logic               data_valid;
    logic               frame_err;
    logic               locked;
    modport master (output bck, lrck, sdata, input ldata, rdata, data_valid, frame_err, locked);
    modport slave (input bck, lrck, sdata, output ldata, rdata, data_valid, frame_err, locked);
endinterface

// File: rtl/dai_receiver.sv
// dai_receiver: oversamples an MSB-first left-justified DAI link (32 BCK per slot)
// and recovers one signed left/right pair per LRCK period with a valid strobe.
module dai_receiver #(parameter int bw_data = 16) (
    input logic clk,
    input logic rst,
    dai_receiver_if.slave dai
);
    localparam int cw = $clog2(bw_data + 1);
    typedef enum logic [1:0] {idle, left_slot, right_slot} state_t;
    state_t             state;
    logic [2:0]         bck_s;
    logic [2:0]         lr_s;
    logic [1:0]         sd_s;
    logic [bw_data-1:0] sreg;
    logic [bw_data-1:0] lhold;
    logic [cw-1:0]      bitcnt;
    logic               lok;
    logic               bck_rise;
    logic               lr_rise;
    logic               lr_fall;
    logic               full;
    logic               slot_end;
    always_comb begin
        bck_rise = bck_s[1] & ~bck_s[2];
        lr_rise  = lr_s[1] & ~lr_s[2];
        lr_fall  = ~lr_s[1] & lr_s[2];
        full     = bitcnt == cw'(bw_data);
        slot_end = (state == left_slot) ? lr_fall : lr_rise;
    end
    // slot end is judged on the old bitcnt/sreg; a coincident bck_rise becomes bit 0 of the new slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= idle;
            bck_s          <= '0;
            lr_s           <= '0;
            sd_s           <= '0;
            sreg           <= '0;
            lhold          <= '0;
            bitcnt         <= '0;
            lok            <= 1'b0;
            dai.ldata      <= '0;
            dai.rdata      <= '0;
            dai.data_valid <= 1'b0;
            dai.frame_err  <= 1'b0;
            dai.locked     <= 1'b0;
        end else begin
            bck_s          <= {bck_s[1:0], dai.bck};
            lr_s           <= {lr_s[1:0], dai.lrck};
            sd_s           <= {sd_s[0], dai.sdata};
            dai.data_valid <= 1'b0;
            dai.frame_err  <= 1'b0;
            if (bck_rise && (slot_end || !full))
                sreg <= bw_data'({sreg, sd_s[1]});
            if (slot_end)
                bitcnt <= cw'(bck_rise);
            else if (bck_rise && !full)
                bitcnt <= bitcnt + cw'(1);
            if (slot_end) begin
                case (state)
                    idle: begin
                        state      <= left_slot;
                        dai.locked <= 1'b1;
                    end
                    left_slot: begin
                        if (full)
                            lhold <= sreg;
                        lok           <= full;
                        dai.frame_err <= !full;
                        state         <= right_slot;
                    end
                    default: begin
                        if (full && lok) begin
                            dai.ldata      <= lhold;
                            dai.rdata      <= sreg;
                            dai.data_valid <= 1'b1;
                        end
                        dai.frame_err <= !full;
                        lok           <= 1'b0;
                        state         <= left_slot;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dai_receiver.sv
// tb_dai_receiver: drives a DAI source into a 16-bit and a 24-bit receiver and
// checks every recovered pair, error pulse and lock state against a slot model.
`timescale 1ns/1ps
module tb_dai_receiver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bck = 1'b0;
    logic lrck = 1'b0;
    logic sdata = 1'b0;
    always #8 clk = ~clk;

    dai_receiver_if #(.bw_data(16)) d16();
    dai_receiver_if #(.bw_data(24)) d24();
    assign d16.bck = bck;
    assign d16.lrck = lrck;
    assign d16.sdata = sdata;
    assign d24.bck = bck;
    assign d24.lrck = lrck;
    assign d24.sdata = sdata;
    dai_receiver #(.bw_data(16)) dut16 (.clk(clk), .rst(rst), .dai(d16));
    dai_receiver #(.bw_data(24)) dut24 (.clk(clk), .rst(rst), .dai(d24));

    typedef struct { logic [31:0] lw; logic [31:0] rw; } pair_t;
    typedef struct {
        logic [31:0] lw; logic [31:0] rw; int lb; int rb;
        logic [15:0] el; logic [15:0] er; bit edv; int efe;
    } vec_t;

    pair_t q0[$];
    pair_t q1[$];
    vec_t tbl[11];
    int nvec = 0;
    int nerr = 0;
    int fe_exp[2] = '{0, 0};
    int fe_seen[2] = '{0, 0};
    int cyc = 0;
    int lr_cyc = -100;
    logic lr_prev = 1'b0;
    int hbck = 177;
    logic [31:0] last_l[2] = '{32'h0, 32'h0};
    logic [31:0] last_r[2] = '{32'h0, 32'h0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] top_bits(input logic [31:0] w, input int bw);
        return w >> (32 - bw);
    endfunction

    // a complete frame yields a pair only if both slots carried at least bw bits
    task automatic model(input int k, input int bw, input logic [31:0] lw, input logic [31:0] rw, input int lb, input int rb);
        pair_t p;
        p.lw = lw;
        p.rw = rw;
        fe_exp[k] += int'(lb < bw) + int'(rb < bw);
        if (lb >= bw && rb >= bw) begin
            if (k == 0) q0.push_back(p);
            else q1.push_back(p);
        end
    endtask

    task automatic mon(input int k, input int bw, input logic dv, input logic fe, input logic [31:0] l, input logic [31:0] r);
        pair_t p;
        int n;
        int d;
        if (rst) begin
            last_l[k] = 32'h0;
            last_r[k] = 32'h0;
            return;
        end
        if (dv || fe) chk($sformatf("dv_fe_excl%0d", k), {31'b0, dv & fe}, 32'h0);
        if (fe) fe_seen[k]++;
        if (dv) begin
            n = (k == 0) ? q0.size() : q1.size();
            chk($sformatf("dv_pending%0d", k), {31'b0, n != 0}, 32'h1);
            if (n != 0) begin
                if (k == 0) p = q0.pop_front();
                else p = q1.pop_front();
                chk($sformatf("ldata%0d", k), l, top_bits(p.lw, bw));
                chk($sformatf("rdata%0d", k), r, top_bits(p.rw, bw));
            end
            d = cyc - lr_cyc;
            nvec++;
            if (d < 2 || d > 4) begin
                nerr++;
                $display("FAIL dv_latency%0d: got %0d cycles expected 2..4", k, d);
            end
        end else begin
            chk($sformatf("hold_l%0d", k), l, last_l[k]);
            chk($sformatf("hold_r%0d", k), r, last_r[k]);
        end
        last_l[k] = l;
        last_r[k] = r;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (lrck && !lr_prev) lr_cyc = cyc;
        lr_prev = lrck;
    end

    always @(negedge clk) begin
        mon(0, 16, d16.data_valid, d16.frame_err, 32'(d16.ldata), 32'(d16.rdata));
        mon(1, 24, d24.data_valid, d24.frame_err, 32'(d24.ldata), 32'(d24.rdata));
    end

    // each bit starts on a BCK falling edge, where LRCK may also toggle
    task automatic send_slot(input logic lr, input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            bck = 1'b0;
            if (i == 0) lrck = lr;
            sdata = w[31-i];
            #(hbck);
            bck = 1'b1;
            #(hbck);
        end
    endtask

    task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw, input int lb, input int rb, input bit model16);
        if (model16) model(0, 16, lw, rw, lb, rb);
        model(1, 24, lw, rw, lb, rb);
        send_slot(1'b1, lw, lb);
        send_slot(1'b0, rw, rb);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_l16"}, 32'(d16.ldata), 32'h0);
        chk({tag, "_r16"}, 32'(d16.rdata), 32'h0);
        chk({tag, "_flags16"}, {29'b0, d16.data_valid, d16.frame_err, d16.locked}, 32'h0);
        chk({tag, "_l24"}, 32'(d24.ldata), 32'h0);
        chk({tag, "_r24"}, 32'(d24.rdata), 32'h0);
        chk({tag, "_flags24"}, {29'b0, d24.data_valid, d24.frame_err, d24.locked}, 32'h0);
    endtask

    initial begin
        tbl[0]  = '{32'h2710FFFF, 32'h27100000, 32, 32, 16'h2710, 16'h2710, 1'b1, 0};
        tbl[1]  = '{32'h2710A5A5, 32'h27105A5A, 32, 32, 16'h2710, 16'h2710, 1'b1, 0};
        tbl[2]  = '{32'h27101234, 32'h2710FFFF, 32, 32, 16'h2710, 16'h2710, 1'b1, 0};
        tbl[3]  = '{32'hD8F0FFFF, 32'hD8F00000, 32, 32, 16'hD8F0, 16'hD8F0, 1'b1, 0};
        tbl[4]  = '{32'hD8F0A5A5, 32'hD8F05A5A, 32, 32, 16'hD8F0, 16'hD8F0, 1'b1, 0};
        tbl[5]  = '{32'hD8F01234, 32'hD8F0FFFF, 32, 32, 16'hD8F0, 16'hD8F0, 1'b1, 0};
        tbl[6]  = '{32'h80015A5A, 32'h7FFEC3C3, 32, 32, 16'h8001, 16'h7FFE, 1'b1, 0};
        tbl[7]  = '{32'h8001C3C3, 32'h7FFE5A5A, 32, 32, 16'h8001, 16'h7FFE, 1'b1, 0};
        tbl[8]  = '{32'h80010000, 32'h7FFE0000, 10, 32, 16'h0000, 16'h0000, 1'b0, 1};
        tbl[9]  = '{32'h8001FFFF, 32'h7FFEFFFF, 32, 32, 16'h8001, 16'h7FFE, 1'b1, 0};
        tbl[10] = '{32'h123456A5, 32'hFEDCBA3C, 32, 32, 16'h1234, 16'hFEDC, 1'b1, 0};
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst = 1'b0;
        #0.5;
        send_slot(1'b0, 32'h5A5A5A5A, 13);
        chk("no_lock_mid_right", {31'b0, d16.locked}, 32'h0);
        for (int i = 0; i < 11; i++) begin
            pair_t p;
            p.lw = {tbl[i].el, 16'h0};
            p.rw = {tbl[i].er, 16'h0};
            if (tbl[i].edv) q0.push_back(p);
            fe_exp[0] += tbl[i].efe;
            send_frame(tbl[i].lw, tbl[i].rw, tbl[i].lb, tbl[i].rb, 1'b0);
        end
        chk("locked16_run", {31'b0, d16.locked}, 32'h1);
        send_slot(1'b1, 32'h11110000, 32);
        send_slot(1'b0, 32'h22220000, 12);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk_reset_state("midreset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #0.5;
        send_slot(1'b0, 32'h0, 20);
        send_frame(32'h12345678, 32'h9ABCDEF0, 32, 32, 1'b1);
        for (int i = 0; i < 16; i++) begin
            hbck = int'($urandom_range(50, 120));
            send_frame($urandom, $urandom,
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 31)) : 32,
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 31)) : 32, 1'b1);
        end
        send_slot(1'b1, 32'h0, 2);
        repeat (10) @(posedge clk);
        chk("locked16_end", {31'b0, d16.locked}, 32'h1);
        chk("locked24_end", {31'b0, d24.locked}, 32'h1);
        chk("pairs_left16", q0.size(), 32'h0);
        chk("pairs_left24", q1.size(), 32'h0);
        chk("frame_err16", fe_seen[0], fe_exp[0]);
        chk("frame_err24", fe_seen[1], fe_exp[1]);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
